// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } tx_state_t;

  // Parity selection codes for the PARITY parameter.
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Clock cycles per bit, rounded to the nearest integer.
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with show-ahead read data and an occupancy count.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rd_ptr_q];
  // Writes while full are dropped; the producer already sees ready low.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control registers, flushed by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter (5..9 data bits, optional parity, 1/2 stop bits) fed by a FIFO.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = PAR_NONE,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          TxD_data,
  input  logic                          TxD_start,
  output logic                          TxD_ready,
  output logic                          TxD,
  output logic                          TxD_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV = baud_div(CLK_HZ, BAUD);
  localparam int BW  = $clog2(DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  if (DIV < 2) begin : g_chk_div
    $fatal(1, "uart_tx_fifo: clock divider must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_bits
    $fatal(1, "uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_chk_par
    $fatal(1, "uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
    $fatal(1, "uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $fatal(1, "uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  // Parity over the whole captured word; odd parity is the inverse of even.
  function automatic logic par_calc(input logic [DATA_BITS-1:0] w);
    return (PARITY == PAR_ODD) ? ~(^w) : ^w;
  endfunction

  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_full, fifo_empty, pop;

  tx_state_t            state_q, state_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 load;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (TxD_start),
    .wdata (TxD_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign TxD_ready = !fifo_full;
  assign TxD       = txd_q;
  assign TxD_busy  = busy_q;

  // Frame sequencing: each bit lasts DIV cycles; the next line level is
  // computed here so TxD comes straight from a flop.
  always_comb begin
    state_d = state_q;
    txd_d   = txd_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    load    = 1'b0;
    pop     = 1'b0;
    if (state_q == IDLE) begin
      txd_d = 1'b1;
      load  = !fifo_empty;
    end else if (baud_q != BAUD_LAST) begin
      baud_d = baud_q + 1'b1;
    end else begin
      baud_d = '0;
      case (state_q)
        START: begin
          state_d = DATA;
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = '0;
        end
        DATA: begin
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY != PAR_NONE) begin
              state_d = PAR;
              txd_d   = par_q;
            end else begin
              state_d = STOP;
              txd_d   = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
        PAR: begin
          state_d = STOP;
          txd_d   = 1'b1;
          bit_d   = '0;
        end
        STOP: begin
          if (bit_q == STOP_LAST) begin
            // Chain straight into the next frame when more words wait.
            if (!fifo_empty) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
              txd_d   = 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          txd_d   = 1'b1;
        end
      endcase
    end
    if (load) begin
      pop     = 1'b1;
      shift_d = fifo_rdata;
      par_d   = par_calc(fifo_rdata);
      state_d = START;
      txd_d   = 1'b0;
      baud_d  = '0;
      bit_d   = '0;
    end
  end

  assign busy_d = (state_d != IDLE);

  // FSM and datapath registers; reset aborts any frame and idles the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an integrated transmit FIFO. It serialises words onto a single line as start bit, 5–9 data bits LSB-first, optional parity, and 1 or 2 stop bits. The bit rate comes from an internal divider. The block replaces the fixed 8N1 async_transmitter and sits between the result-streaming logic of the matrix engine and the board serial pin.

Parameters:
CLK_HZ, 50_000_000, system clock frequency in Hz
BAUD, 115200, line bit rate; DIV = (CLK_HZ + BAUD/2) / BAUD, must be ≥ 2 (elaboration assert)
DATA_BITS, 8, data bits per frame, legal range 5..9 (elaboration assert)
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, FIFO entries, power of two ≥ 2

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
TxD_data  in  DATA_BITS  word to send
TxD_start  in  1  write strobe; word accepted on a rising edge where TxD_start && TxD_ready
TxD_ready  out  1  FIFO not full
TxD  out  1  serial line, registered, idle high
TxD_busy  out  1  FIFO non-empty or frame in progress
fifo_count  out  $clog2(FIFO_DEPTH)+1  words held in the FIFO (excludes the frame currently shifting)

Behaviour:
- Reset (asynchronous assert, synchronous release): TxD=1, TxD_busy=0, TxD_ready=1, fifo_count=0, FSM=IDLE, FIFO flushed. Reset mid-frame aborts the frame; TxD goes to 1 immediately.
- One clock, one reset; all outputs are registered or decoded from registers; no combinational path from TxD_start to TxD.
- FIFO: write when TxD_start && !full; a write while full is dropped silently (ready already low). Pop is issued by the FSM only.
- Simultaneous push and pop: count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Baud counter: counts 0..DIV-1. It is cleared on every transition out of IDLE, so each bit lasts exactly DIV cycles.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: if FIFO non-empty, pop into the shift register and go to START. TxD=0 from the next edge, so the line is low one cycle after the accepting edge when idle and empty.
  - START: hold TxD=0 for DIV cycles, then go to DATA.
  - DATA: shift LSB first, DATA_BITS bit-periods. Then go to PAR if PARITY != 0, else STOP.
  - PAR: parity bit = XOR of data bits (even), or its inverse (odd). It is computed over the captured word, not the shifted one.
  - STOP: TxD=1 for STOP_BITS*DIV cycles. At the end, if the FIFO is non-empty, pop and go straight to START with no extra idle cycle; otherwise go to IDLE.
- Frame length: (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * DIV cycles.
- TxD_busy: high from the cycle after an accepted write until the last stop-bit cycle completes with the FIFO empty.
- Words in the FIFO are never altered by later writes or by TxD_data changes.

Decomposition:
- Package uart_pkg holds:
  - tx_state_t enum (IDLE, START, DATA, PAR, STOP)
  - parity_t constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2
  - function baud_div(clk_hz, baud) returning the rounded DIV
- One sub-module, uart_sync_fifo: parametrised on WIDTH/DEPTH, with push/pop/full/empty/count.
- FSM, baud counter and shift register stay in uart_tx_fifo.

Test Plan:
- 8N1, CLK_HZ=400, BAUD=100 (DIV=4): write 8'hB3 → TxD low 1 cycle later for 4 cycles, then 1,1,0,0,1,1,0,1 at 4 cycles each, then high 4 cycles. TxD_busy is high for exactly 40 cycles.
- DATA_BITS=7, PARITY=2 (even), STOP_BITS=2: write 7'h55 → parity bit 0. Frame is 11 bit-periods. Repeat with PARITY=1 → parity bit 1.
- FIFO_DEPTH=4: 5 consecutive writes while idle → TxD_ready falls after the 5th accept. The first word pops immediately, so 4 are queued and fifo_count=4. A 6th write is dropped. The 5 frames are back-to-back with no gap between stop and start. The dropped word never appears on TxD.
- Write on the same cycle that the FSM pops at end of STOP: fifo_count is unchanged and the order is preserved.
- Assert rst_n low in the middle of DATA of frame 2 of 3 → TxD=1 and TxD_busy=0 asynchronously. After release the line stays idle and no remaining words are sent.
- Change TxD_data every cycle while a frame shifts → the transmitted bits match only the value captured at the accepting edge.
